// File: rtl/regfile_access_ctrl.sv
// Operand-fetch controller for a small register file.
// Issues a read on the registered RF read port, captures both operands one
// cycle later, and presents them on a valid/ready handshake. A writeback that
// lands in the same cycle as the read request is bypassed into the captured
// operand, because the RF returns the pre-write value in that case.
module regfile_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_src1,
    input  logic [ADDR_W-1:0] req_src2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_data1,
    output logic [DATA_W-1:0] op_data2,
    output logic              rf_read_en,
    output logic [ADDR_W-1:0] rf_read_adr1,
    output logic [ADDR_W-1:0] rf_read_adr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_adr,
    output logic [DATA_W-1:0] rf_write_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        VALID   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic              byp1_q, byp1_d;
    logic              byp2_q, byp2_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic              op_valid_q, op_valid_d;
    logic [DATA_W-1:0] op_data1_q, op_data1_d;
    logic [DATA_W-1:0] op_data2_q, op_data2_d;
    logic              accept;

    // Writeback is a straight pass-through, gated off while in reset.
    always_comb begin
        rf_write_en   = wb_valid & ~reset;
        rf_write_adr  = wb_adr;
        rf_write_data = wb_data;
    end

    // Handshake, RF read port drive, and next-state/next-data computation.
    always_comb begin
        req_ready    = ~reset & ((state_q == IDLE) | ((state_q == VALID) & op_ready));
        accept       = req_valid & req_ready;
        rf_read_en   = accept;
        rf_read_adr1 = accept ? req_src1 : src1_q;
        rf_read_adr2 = accept ? req_src2 : src2_q;

        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        byp1_d     = byp1_q;
        byp2_d     = byp2_q;
        byp_data_d = byp_data_q;
        op_valid_d = op_valid_q;
        op_data1_d = op_data1_q;
        op_data2_d = op_data2_q;

        case (state_q)
            CAPTURE: begin
                op_data1_d = byp1_q ? byp_data_q : rf_read_data1;
                op_data2_d = byp2_q ? byp_data_q : rf_read_data2;
                op_valid_d = 1'b1;
                state_d    = VALID;
            end
            VALID: begin
                // Held operands are a snapshot; later writes never touch them.
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request (from IDLE, or back-to-back out of VALID) overrides.
        if (accept) begin
            src1_d     = req_src1;
            src2_d     = req_src2;
            byp1_d     = wb_valid & (wb_adr == req_src1);
            byp2_d     = wb_valid & (wb_adr == req_src2);
            byp_data_d = wb_data;
            op_valid_d = 1'b0;
            state_d    = CAPTURE;
        end
    end

    // State and operand registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
            op_valid_q <= 1'b0;
            op_data1_q <= '0;
            op_data2_q <= '0;
        end else begin
            state_q    <= state_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            byp_data_q <= byp_data_d;
            op_valid_q <= op_valid_d;
            op_data1_q <= op_data1_d;
            op_data2_q <= op_data2_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_data1 = op_data1_q;
    assign op_data2 = op_data2_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed and randomized bench for regfile_access_ctrl with a behavioural
// 4x16 register file (registered read, read returns pre-write value).
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_src1 = 2'd0;
    logic [1:0]  req_src2 = 2'd0;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_adr = 2'd0;
    logic [15:0] wb_data = 16'h0;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [15:0] op_data1, op_data2;
    logic        rf_read_en;
    logic [1:0]  rf_read_adr1, rf_read_adr2;
    logic [15:0] rf_read_data1 = 16'h0;
    logic [15:0] rf_read_data2 = 16'h0;
    logic        rf_write_en;
    logic [1:0]  rf_write_adr;
    logic [15:0] rf_write_data;

    logic [15:0] rf_mem [4] = '{default: 16'h0};
    logic [15:0] ref_mem [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(16), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_data1(op_data1), .op_data2(op_data2),
        .rf_read_en(rf_read_en), .rf_read_adr1(rf_read_adr1), .rf_read_adr2(rf_read_adr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_write_en(rf_write_en), .rf_write_adr(rf_write_adr), .rf_write_data(rf_write_data)
    );

    // Register file model: registered read port, write visible next cycle.
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_adr] <= rf_write_data;
        if (rf_read_en) begin
            rf_read_data1 <= rf_mem[rf_read_adr1];
            rf_read_data2 <= rf_mem[rf_read_adr2];
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_src1 = 2'd1; req_src2 = 2'd2;
        wb_valid = 1'b1; wb_adr = 2'd1; wb_data = 16'hDEAD; op_ready = 1'b1;
        step(); step(); #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %b want 0", op_valid); end
        checks++; if (op_data1 !== 16'h0) begin errors++; $display("FAIL rst_op_data1: got %h want 0000", op_data1); end
        checks++; if (op_data2 !== 16'h0) begin errors++; $display("FAIL rst_op_data2: got %h want 0000", op_data2); end
        checks++; if (rf_read_en !== 1'b0) begin errors++; $display("FAIL rst_read_en: got %b want 0", rf_read_en); end
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en: got %b want 0", rf_write_en); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        reset = 1'b0; req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic_read();
        wb_valid = 1'b1; wb_adr = 2'd1; wb_data = 16'h1234; #1;
        checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL wr_en: got %b want 1", rf_write_en); end
        checks++; if (rf_write_data !== 16'h1234) begin errors++; $display("FAIL wr_data: got %h want 1234", rf_write_data); end
        step();
        wb_adr = 2'd2; wb_data = 16'hBEEF;
        step();
        wb_valid = 1'b0; req_valid = 1'b1; req_src1 = 2'd1; req_src2 = 2'd2; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_req_ready: got %b want 1", req_ready); end
        checks++; if (rf_read_en !== 1'b1) begin errors++; $display("FAIL basic_read_en: got %b want 1", rf_read_en); end
        checks++; if (rf_read_adr2 !== 2'd2) begin errors++; $display("FAIL basic_read_adr2: got %0d want 2", rf_read_adr2); end
        step();
        req_valid = 1'b0; req_src1 = 2'd3; #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL cap_op_valid: got %b want 0", op_valid); end
        checks++; if (rf_read_en !== 1'b0) begin errors++; $display("FAIL cap_read_en: got %b want 0", rf_read_en); end
        checks++; if (rf_read_adr1 !== 2'd1) begin errors++; $display("FAIL cap_read_adr1_hold: got %0d want 1", rf_read_adr1); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cap_req_ready: got %b want 0", req_ready); end
        step(); #1;
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_op_valid: got %b want 1", op_valid); end
        checks++; if (op_data1 !== 16'h1234) begin errors++; $display("FAIL basic_d1: got %h want 1234", op_data1); end
        checks++; if (op_data2 !== 16'hBEEF) begin errors++; $display("FAIL basic_d2: got %h want beef", op_data2); end
        op_ready = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL valid_ready_req_ready: got %b want 1", req_ready); end
        step();
        op_ready = 1'b0; #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b want 0", op_valid); end
    endtask

    task automatic test_bypass();
        wb_valid = 1'b1; wb_adr = 2'd3; wb_data = 16'h00AA;
        req_valid = 1'b1; req_src1 = 2'd3; req_src2 = 2'd3;
        step();
        req_valid = 1'b0; wb_adr = 2'd3; wb_data = 16'h5555;
        step();
        wb_valid = 1'b0; #1;
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL byp_op_valid: got %b want 1", op_valid); end
        checks++; if (op_data1 !== 16'h00AA) begin errors++; $display("FAIL byp_d1: got %h want 00aa", op_data1); end
        checks++; if (op_data2 !== 16'h00AA) begin errors++; $display("FAIL byp_d2: got %h want 00aa", op_data2); end
        step(); #1;
        checks++; if (op_data1 !== 16'h00AA) begin errors++; $display("FAIL byp_hold_d1: got %h want 00aa", op_data1); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        // Only source 1 matches the same-cycle write.
        wb_valid = 1'b1; wb_adr = 2'd0; wb_data = 16'h0F0F;
        req_valid = 1'b1; req_src1 = 2'd0; req_src2 = 2'd1;
        step();
        req_valid = 1'b0; wb_valid = 1'b0;
        step(); #1;
        checks++; if (op_data1 !== 16'h0F0F) begin errors++; $display("FAIL byp1only_d1: got %h want 0f0f", op_data1); end
        checks++; if (op_data2 !== 16'h1234) begin errors++; $display("FAIL byp1only_d2: got %h want 1234", op_data2); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_src1 = 2'd1; req_src2 = 2'd2;
        step();
        req_valid = 1'b0;
        step();
        req_valid = 1'b1; req_src1 = 2'd3; req_src2 = 2'd1; op_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_valid = (i == 2); wb_adr = 2'd2; wb_data = 16'h2222; #1;
            checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, op_valid); end
            checks++; if (op_data1 !== 16'h1234) begin errors++; $display("FAIL stall_d1[%0d]: got %h want 1234", i, op_data1); end
            checks++; if (op_data2 !== 16'hBEEF) begin errors++; $display("FAIL stall_d2[%0d]: got %h want beef", i, op_data2); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); end
            step();
        end
        wb_valid = 1'b0; op_ready = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready: got %b want 1", req_ready); end
        checks++; if (rf_read_en !== 1'b1) begin errors++; $display("FAIL b2b_read_en: got %b want 1", rf_read_en); end
        step();
        op_ready = 1'b0; req_valid = 1'b0; #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL b2b_capture_valid: got %b want 0", op_valid); end
        step(); #1;
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", op_valid); end
        checks++; if (op_data1 !== 16'h5555) begin errors++; $display("FAIL b2b_d1: got %h want 5555", op_data1); end
        checks++; if (op_data2 !== 16'h1234) begin errors++; $display("FAIL b2b_d2: got %h want 1234", op_data2); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_reset_capture();
        req_valid = 1'b1; req_src1 = 2'd2; req_src2 = 2'd3;
        step();
        req_valid = 1'b0; #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL abort_capture_valid: got %b want 0", op_valid); end
        reset = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_rst_req_ready: got %b want 0", req_ready); end
        step();
        reset = 1'b0; #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL abort_op_valid: got %b want 0", op_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b want 1", req_ready); end
        op_ready = 1'b1;
        step(); step(); #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL abort_no_delivery: got %b want 0", op_valid); end
        op_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] q1[$];
        logic [15:0] q2[$];
        logic [15:0] e1, e2, prev_d1, prev_d2;
        logic prev_hold;
        ref_mem[0] = 16'h0F0F; ref_mem[1] = 16'h1234; ref_mem[2] = 16'h2222; ref_mem[3] = 16'h5555;
        prev_hold = 1'b0; prev_d1 = 16'h0; prev_d2 = 16'h0;
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_src1  = 2'($urandom_range(0, 3));
            req_src2  = 2'($urandom_range(0, 3));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_adr    = 2'($urandom_range(0, 3));
            wb_data   = 16'($urandom);
            op_ready  = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_hold) begin
                checks++; if (op_valid !== 1'b1 || op_data1 !== prev_d1 || op_data2 !== prev_d2) begin
                    errors++; $display("FAIL rnd_hold[%0d]: got %b %h %h want 1 %h %h", i, op_valid, op_data1, op_data2, prev_d1, prev_d2); end
            end
            if (op_valid && op_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious[%0d]: got delivery want none", i);
                end else begin
                    e1 = q1.pop_front(); e2 = q2.pop_front();
                    if (op_data1 !== e1 || op_data2 !== e2) begin
                        errors++; $display("FAIL rnd_data[%0d]: got %h %h want %h %h", i, op_data1, op_data2, e1, e2); end
                end
            end
            if (req_valid && req_ready) begin
                q1.push_back((wb_valid && wb_adr == req_src1) ? wb_data : ref_mem[req_src1]);
                q2.push_back((wb_valid && wb_adr == req_src2) ? wb_data : ref_mem[req_src2]);
            end
            if (wb_valid) ref_mem[wb_adr] = wb_data;
            prev_hold = op_valid && !op_ready;
            prev_d1 = op_data1; prev_d2 = op_data2;
            step();
        end
        req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (op_valid) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL drain_spurious[%0d]: got delivery want none", i);
                end else begin
                    e1 = q1.pop_front(); e2 = q2.pop_front();
                    if (op_data1 !== e1 || op_data2 !== e2) begin
                        errors++; $display("FAIL drain_data[%0d]: got %h %h want %h %h", i, op_data1, op_data2, e1, e2); end
                end
            end
            step();
        end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL rnd_undelivered: got %0d pending want 0", q1.size()); end
        op_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_bypass();
        test_back_to_back();
        test_reset_capture();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
